// File: rtl/cte_pkg.sv
// Shared definitions for the colour-transform engine front end: byte lanes,
// serializer states and CTE mode encodings.
package cte_pkg;

    localparam int BW = 8;

    localparam int U_LANE  = 3;
    localparam int Y0_LANE = 2;
    localparam int V_LANE  = 1;
    localparam int Y1_LANE = 0;

    localparam logic OP_YUV2RGB = 1'b0;
    localparam logic OP_RGB2YUV = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_U    = 3'd1,
        ST_Y0   = 3'd2,
        ST_V    = 3'd3,
        ST_Y1   = 3'd4
    } ser_state_e;

    // Byte of a macropixel word presented in a given serializer state; 0 when idle.
    function automatic logic [BW-1:0] lane_byte(input logic [4*BW-1:0] word,
                                                input ser_state_e     st);
        logic [BW-1:0] b;
        case (st)
            ST_U:    b = word[U_LANE*BW  +: BW];
            ST_Y0:   b = word[Y0_LANE*BW +: BW];
            ST_V:    b = word[V_LANE*BW  +: BW];
            ST_Y1:   b = word[Y1_LANE*BW +: BW];
            default: b = {BW{1'b0}};
        endcase
        return b;
    endfunction

endpackage

// File: rtl/macropixel_fifo.sv
// Synchronous FIFO of macropixel words with an explicit occupancy count,
// registered status flags and a sticky overflow flag.
module macropixel_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             full_q;
    logic             empty_q;
    logic             overflow_q;
    logic             push_s;
    logic             pop_s;

    // Accepted push/pop and next occupancy; a push while full is dropped even alongside a pop.
    always_comb begin
        push_s  = wr_en & ~full_q;
        pop_s   = rd_en & ~empty_q;
        count_d = count_q;
        if (push_s && !pop_s) begin
            count_d = count_q + 1'b1;
        end else if (pop_s && !push_s) begin
            count_d = count_q - 1'b1;
        end else begin
            count_d = count_q;
        end
    end

    // Pointers, count, status flags and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {(AW+1){1'b0}};
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (wr_en && full_q) begin
                overflow_q <= 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == FULL_CNT);
            empty_q <= (count_d == {(AW+1){1'b0}});
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;
    assign level    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/yuv422_feeder.sv
// Feeds packed YUV 4:2:2 macropixels into the CTE one byte per accepted cycle
// (U, Y0, V, Y1), honouring the busy stall and framing a fixed pixel count.
module yuv422_feeder
    import cte_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int FRAME_PIXELS = 128,
    parameter int CNT_W        = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [31:0]              wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     start,
    output logic                     frame_active,
    output logic                     frame_done,
    output logic                     op_mode,
    output logic                     in_en,
    output logic [BW-1:0]            yuv_in,
    input  logic                     busy
);

    localparam logic [CNT_W-1:0] FRAME_PAIRS = CNT_W'(FRAME_PIXELS / 2);
    localparam logic [CNT_W-1:0] PAIR_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    ser_state_e        state_q, state_d;
    logic [4*BW-1:0]   hold_q, hold_d;
    logic [CNT_W-1:0]  pairs_q, pairs_d;
    logic              active_q, active_d;
    logic              done_q, done_d;
    logic              in_en_q, in_en_d;
    logic [BW-1:0]     yuv_q, yuv_d;
    logic              pop_s;
    logic              accept_s;
    logic              load_s;
    logic [4*BW-1:0]   fifo_data_s;

    macropixel_fifo #(
        .WIDTH (4*BW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop_s),
        .rd_data  (fifo_data_s),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow)
    );

    // Serializer next state, holding-register load, frame counter and registered CTE outputs.
    always_comb begin
        accept_s = in_en_q & ~busy;
        load_s   = start & ~active_q;
        state_d  = state_q;
        hold_d   = hold_q;
        pairs_d  = load_s ? FRAME_PAIRS : pairs_q;
        active_d = active_q | load_s;
        done_d   = 1'b0;
        pop_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (active_q && !empty && (pairs_q != {CNT_W{1'b0}})) begin
                    pop_s   = 1'b1;
                    hold_d  = fifo_data_s;
                    state_d = ST_U;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_U:  state_d = accept_s ? ST_Y0 : ST_U;
            ST_Y0: state_d = accept_s ? ST_V  : ST_Y0;
            ST_V:  state_d = accept_s ? ST_Y1 : ST_V;
            ST_Y1: begin
                if (accept_s) begin
                    pairs_d = pairs_q - 1'b1;
                    if (pairs_q == PAIR_ONE) begin
                        active_d = 1'b0;
                        done_d   = 1'b1;
                        state_d  = ST_IDLE;
                    end else if (active_q && !empty) begin
                        // Chain straight into the next word so Y1 is followed by U with no bubble.
                        pop_s   = 1'b1;
                        hold_d  = fifo_data_s;
                        state_d = ST_U;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_Y1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_en_d = (state_d != ST_IDLE);
        yuv_d   = lane_byte(hold_d, state_d);
    end

    // State, holding register, frame counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            hold_q   <= {(4*BW){1'b0}};
            pairs_q  <= {CNT_W{1'b0}};
            active_q <= 1'b0;
            done_q   <= 1'b0;
            in_en_q  <= 1'b0;
            yuv_q    <= {BW{1'b0}};
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            pairs_q  <= pairs_d;
            active_q <= active_d;
            done_q   <= done_d;
            in_en_q  <= in_en_d;
            yuv_q    <= yuv_d;
        end
    end

    assign frame_active = active_q;
    assign frame_done   = done_q;
    assign in_en        = in_en_q;
    assign yuv_in       = yuv_q;
    assign op_mode      = OP_YUV2RGB;

endmodule

// File: tb/tb_yuv422_feeder.sv
// Directed bench for yuv422_feeder (DEPTH=4, FRAME_PIXELS=4 -> 2 macropixels per frame).
module tb_yuv422_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        full, empty, overflow;
    logic [2:0]  level;
    logic        start;
    logic        frame_active, frame_done, op_mode, in_en;
    logic [7:0]  yuv_in;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    yuv422_feeder #(
        .DEPTH        (4),
        .FRAME_PIXELS (4),
        .CNT_W        (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .empty        (empty),
        .level        (level),
        .overflow     (overflow),
        .start        (start),
        .frame_active (frame_active),
        .frame_done   (frame_done),
        .op_mode      (op_mode),
        .in_en        (in_en),
        .yuv_in       (yuv_in),
        .busy         (busy)
    );

    typedef struct {
        logic        wr;
        logic [31:0] d;
        logic        st;
        logic        bz;
        logic        e_en;
        logic [7:0]  e_yuv;
        logic        e_done;
        logic [2:0]  e_lvl;
        logic        e_act;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        tick();
        wr_en   = 1'b0;
    endtask

    // Starts a frame and collects bytes until frame_done; optionally re-pulses start after byte start_at.
    task automatic run_frame(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                             input int start_at, input logic [2:0] exp_lvl);
        logic [7:0] exp_b [8];
        int idx  = 0;
        int gaps = 0;
        bit done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_b[k]     = w0[31-8*k -: 8];
            exp_b[4 + k] = w1[31-8*k -: 8];
        end
        start = 1'b1;
        for (int c = 0; c < 60 && !done; c++) begin
            tick();
            start = 1'b0;
            if (frame_done) begin
                done = 1'b1;
                chk({tag, " in_en at done"}, {31'd0, in_en}, 32'd0);
                chk({tag, " level after done"}, {29'd0, level}, {29'd0, exp_lvl});
                chk({tag, " active at done"}, {31'd0, frame_active}, 32'd0);
            end else if (in_en) begin
                if (idx < 8) begin
                    chk($sformatf("%s byte%0d", tag, idx), {24'd0, yuv_in}, {24'd0, exp_b[idx]});
                end
                if (idx == start_at) begin
                    start = 1'b1;
                end
                idx++;
            end else if (idx > 0) begin
                gaps++;
            end
        end
        chk({tag, " frame_done seen"}, {31'd0, done}, 32'd1);
        chk({tag, " byte count"}, 32'(idx), 32'd8);
        chk({tag, " bubbles"}, 32'(gaps), 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = 32'h0;
        start   = 1'b0;
        busy    = 1'b0;
        #3;
        chk("rst in_en", {31'd0, in_en}, 32'd0);
        chk("rst yuv_in", {24'd0, yuv_in}, 32'd0);
        chk("rst op_mode", {31'd0, op_mode}, 32'd0);
        chk("rst full", {31'd0, full}, 32'd0);
        chk("rst empty", {31'd0, empty}, 32'd1);
        chk("rst level", {29'd0, level}, 32'd0);
        chk("rst overflow", {31'd0, overflow}, 32'd0);
        chk("rst active", {31'd0, frame_active}, 32'd0);
        chk("rst done", {31'd0, frame_done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Single frame of two words with a 3-cycle stall on V=0x40 of the second word.
        tbl[0]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1};
        tbl[1]  = '{1'b1, 32'h801080EB, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd1, 1'b1};
        tbl[2]  = '{1'b1, 32'h30554099, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 3'd1, 1'b1};
        tbl[3]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 3'd1, 1'b1};
        tbl[4]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 3'd1, 1'b1};
        tbl[5]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'hEB, 1'b0, 3'd1, 1'b1};
        tbl[6]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'h30, 1'b0, 3'd0, 1'b1};
        tbl[7]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 3'd0, 1'b1};
        tbl[8]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'h40, 1'b0, 3'd0, 1'b1};
        tbl[9]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 8'h40, 1'b0, 3'd0, 1'b1};
        tbl[10] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 8'h40, 1'b0, 3'd0, 1'b1};
        tbl[11] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 8'h40, 1'b0, 3'd0, 1'b1};
        tbl[12] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'h99, 1'b0, 3'd0, 1'b1};
        tbl[13] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0};
        tbl[14] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};

        for (int i = 0; i < 15; i++) begin
            wr_en   = tbl[i].wr;
            wr_data = tbl[i].d;
            start   = tbl[i].st;
            busy    = tbl[i].bz;
            tick();
            chk($sformatf("vec%0d in_en", i), {31'd0, in_en}, {31'd0, tbl[i].e_en});
            if (tbl[i].e_en) begin
                chk($sformatf("vec%0d yuv_in", i), {24'd0, yuv_in}, {24'd0, tbl[i].e_yuv});
            end
            chk($sformatf("vec%0d frame_done", i), {31'd0, frame_done}, {31'd0, tbl[i].e_done});
            chk($sformatf("vec%0d level", i), {29'd0, level}, {29'd0, tbl[i].e_lvl});
            chk($sformatf("vec%0d active", i), {31'd0, frame_active}, {31'd0, tbl[i].e_act});
        end
        wr_en = 1'b0;
        start = 1'b0;
        busy  = 1'b0;

        // Fill to full, overflow on the fifth push, then drain across pointer wrap.
        push(32'h01020304);
        chk("fill level1", {29'd0, level}, 32'd1);
        chk("fill empty", {31'd0, empty}, 32'd0);
        push(32'h05060708);
        push(32'h090A0B0C);
        chk("fill full@3", {31'd0, full}, 32'd0);
        push(32'h0D0E0F10);
        chk("fill level4", {29'd0, level}, 32'd4);
        chk("fill full", {31'd0, full}, 32'd1);
        chk("overflow before", {31'd0, overflow}, 32'd0);
        push(32'hDEADBEEF);
        chk("overflow set", {31'd0, overflow}, 32'd1);
        chk("overflow level", {29'd0, level}, 32'd4);
        run_frame("B1", 32'h01020304, 32'h05060708, -1, 3'd2);
        run_frame("B2", 32'h090A0B0C, 32'h0D0E0F10, -1, 3'd0);
        push(32'h11223344);
        push(32'h55667788);
        push(32'h99AABBCC);
        push(32'hDDEEFF00);
        run_frame("B3", 32'h11223344, 32'h55667788, -1, 3'd2);
        run_frame("B4", 32'h99AABBCC, 32'hDDEEFF00, -1, 3'd0);
        chk("overflow sticky", {31'd0, overflow}, 32'd1);
        chk("drained empty", {31'd0, empty}, 32'd1);

        // Frame boundary: third word waits for the next start.
        push(32'hA1A2A3A4);
        push(32'hB1B2B3B4);
        push(32'hC1C2C3C4);
        run_frame("C1", 32'hA1A2A3A4, 32'hB1B2B3B4, -1, 3'd1);
        push(32'hD1D2D3D4);
        run_frame("C2", 32'hC1C2C3C4, 32'hD1D2D3D4, -1, 3'd0);

        // Start during the second word must not reload the pair counter.
        push(32'h12345678);
        push(32'h9ABCDEF0);
        push(32'h0F1E2D3C);
        run_frame("D", 32'h12345678, 32'h9ABCDEF0, 5, 3'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("D idle%0d in_en", i), {31'd0, in_en}, 32'd0);
        end

        // Reset asserted while V is presented with two words still queued.
        push(32'h4B5A6978);
        push(32'h8796A5B4);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("E U byte", {24'd0, yuv_in}, 32'h0F);
        tick();
        tick();
        chk("E V byte", {24'd0, yuv_in}, 32'h2D);
        chk("E level", {29'd0, level}, 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("E rst in_en", {31'd0, in_en}, 32'd0);
        chk("E rst yuv_in", {24'd0, yuv_in}, 32'd0);
        chk("E rst op_mode", {31'd0, op_mode}, 32'd0);
        chk("E rst full", {31'd0, full}, 32'd0);
        chk("E rst empty", {31'd0, empty}, 32'd1);
        chk("E rst level", {29'd0, level}, 32'd0);
        chk("E rst overflow", {31'd0, overflow}, 32'd0);
        chk("E rst active", {31'd0, frame_active}, 32'd0);
        chk("E rst done", {31'd0, frame_done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("E post%0d in_en", i), {31'd0, in_en}, 32'd0);
        end
        push(32'hCAFEF00D);
        push(32'h600DBEEF);
        run_frame("E2", 32'hCAFEF00D, 32'h600DBEEF, -1, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
